// File: rtl/vga_timing_gen.sv
// Raster timing generator: divides the system clock to a pixel rate and drives VGA
// sync/blank, pixel coordinates and a once-per-frame tick at the start of vertical blanking.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    output logic        display,
    output logic [31:0] X,
    output logic [31:0] Y,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic        VGA_CLK,
    output logic        frame_tick
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DivLast    = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DivHalf    = DW'(CLK_DIV / 2);
    localparam logic [HW-1:0] HLast      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HActEnd    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HSyncStart = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HSyncEnd   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VLast      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VActEnd    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VSyncStart = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VSyncEnd   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] hcnt_q, hcnt_d, x_q;
    logic [VW-1:0] vcnt_q, vcnt_d, y_q;
    logic          pe;
    logic          display_q, display_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          tick_q, tick_d;
    logic          vga_clk_q;

    assign pe = (div_q == DivLast);

    always_comb begin
        div_d  = pe ? '0 : div_q + 1'b1;
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (pe) begin
            if (hcnt_q == HLast) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    // Outputs are decoded from the next counter values so every output names the same pixel.
    always_comb begin
        display_d = (hcnt_d < HActEnd) && (vcnt_d < VActEnd);
        hs_d      = !((hcnt_d >= HSyncStart) && (hcnt_d < HSyncEnd));
        vs_d      = !((vcnt_d >= VSyncStart) && (vcnt_d < VSyncEnd));
        tick_d    = pe && (hcnt_d == '0) && (vcnt_d == VActEnd);
    end

    // Counters reset to the last pixel so the first pe lands on (0,0).
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            div_q     <= '0;
            hcnt_q    <= HLast;
            vcnt_q    <= VLast;
            x_q       <= '0;
            y_q       <= '0;
            display_q <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            tick_q    <= 1'b0;
            vga_clk_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            tick_q    <= tick_d;
            vga_clk_q <= (div_d >= DivHalf);
            if (pe) begin
                hcnt_q    <= hcnt_d;
                vcnt_q    <= vcnt_d;
                x_q       <= hcnt_d;
                y_q       <= vcnt_d;
                display_q <= display_d;
                hs_q      <= hs_d;
                vs_q      <= vs_d;
            end
        end
    end

    assign X           = 32'(x_q);
    assign Y           = 32'(y_q);
    assign display     = display_q;
    assign VGA_BLANK_N = display_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign frame_tick  = tick_q;
    // With one clock per pixel the DAC clock is the inverted system clock.
    assign VGA_CLK     = (CLK_DIV == 1) ? ~CLOCK_50 : vga_clk_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default, reduced CLK_DIV=2, tiny CLK_DIV=1)
// checked every cycle against a closed-form raster model plus literal spot checks.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        disp;
        logic        blank;
        logic        sync;
        logic        hs;
        logic        vs;
        logic        tick;
        logic        vclk;
        logic [31:0] x;
        logic [31:0] y;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    logic        d_disp, d_hs, d_vs, d_blank, d_sync, d_vclk, d_tick;
    logic [31:0] d_x, d_y;
    logic        m_disp, m_hs, m_vs, m_blank, m_sync, m_vclk, m_tick;
    logic [31:0] m_x, m_y;
    logic        s_disp, s_hs, s_vs, s_blank, s_sync, s_vclk, s_tick;
    logic [31:0] s_x, s_y;

    vga_timing_gen u_dflt (
        .CLOCK_50(clk), .resetn(resetn), .display(d_disp), .X(d_x), .Y(d_y),
        .VGA_HS(d_hs), .VGA_VS(d_vs), .VGA_BLANK_N(d_blank), .VGA_SYNC_N(d_sync),
        .VGA_CLK(d_vclk), .frame_tick(d_tick)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) u_mid (
        .CLOCK_50(clk), .resetn(resetn), .display(m_disp), .X(m_x), .Y(m_y),
        .VGA_HS(m_hs), .VGA_VS(m_vs), .VGA_BLANK_N(m_blank), .VGA_SYNC_N(m_sync),
        .VGA_CLK(m_vclk), .frame_tick(m_tick)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_small (
        .CLOCK_50(clk), .resetn(resetn), .display(s_disp), .X(s_x), .Y(s_y),
        .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_BLANK_N(s_blank), .VGA_SYNC_N(s_sync),
        .VGA_CLK(s_vclk), .frame_tick(s_tick)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n = 0;   // clocks since reset release
    bit          chk_en = 1'b0;
    bit          run1 = 1'b0;

    int unsigned d_hs_low = 0, d_disp_cnt = 0, m_vs_low = 0, m_disp_cnt = 0;
    int unsigned d_fall_n[$], d_fall_x[$], m_ticks[$], s_ticks[$];
    logic        d_hs_prev = 1'b1;
    exp_t        m_at290, m_at578;

    // After n clocks, n/d pixels have elapsed; pixel index q=n/d-1 maps to (q%HT, q/HT%VT).
    function automatic exp_t model(input int unsigned cn, input int unsigned d,
                                   input int unsigned ha, input int unsigned hf,
                                   input int unsigned hs, input int unsigned hb,
                                   input int unsigned va, input int unsigned vf,
                                   input int unsigned vs, input int unsigned vb);
        exp_t e;
        int unsigned ht, vt, p, q, h, v;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        e = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        e.vclk = (d == 1) ? 1'b0 : ((cn % d) >= (d / 2));
        p = cn / d;
        if (p > 0) begin
            q = p - 1;
            h = q % ht;
            v = (q / ht) % vt;
            e.x = h;
            e.y = v;
            e.disp = (h < ha) && (v < va);
            e.blank = e.disp;
            e.hs = !((h >= ha + hf) && (h < ha + hf + hs));
            e.vs = !((v >= va + vf) && (v < va + vf + vs));
            e.tick = ((cn % d) == 0) && (h == 0) && (v == va);
        end
        return e;
    endfunction

    task automatic cmp(input string nm, input exp_t a, input exp_t e);
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL %s n=%0d actual=%h required=%h", nm, n, a, e);
        end
    endtask

    task automatic chk(input string nm, input longint a, input longint e);
        n_checks++;
        if (a != e) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, a, e);
        end
    endtask

    always @(posedge clk) begin
        exp_t ad, am, as_;
        if (resetn) n++;
        else n = 0;
        #1;
        if (chk_en) begin
            ad  = '{d_disp, d_blank, d_sync, d_hs, d_vs, d_tick, d_vclk, d_x, d_y};
            am  = '{m_disp, m_blank, m_sync, m_hs, m_vs, m_tick, m_vclk, m_x, m_y};
            as_ = '{s_disp, s_blank, s_sync, s_hs, s_vs, s_tick, s_vclk, s_x, s_y};
            cmp("dflt_model", ad, model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33));
            cmp("mid_model", am, model(n, 2, 16, 2, 4, 2, 6, 2, 2, 2));
            cmp("small_model", as_, model(n, 1, 8, 1, 2, 1, 4, 1, 1, 1));
            if (run1) begin
                if (n >= 1 && n <= 4800) begin
                    if (!d_hs) d_hs_low++;
                    if (d_disp) d_disp_cnt++;
                    if (!d_hs && d_hs_prev) begin
                        d_fall_n.push_back(n);
                        d_fall_x.push_back(d_x);
                    end
                end
                if (n >= 1 && n <= 576) begin
                    if (!m_vs) m_vs_low++;
                    if (m_disp) m_disp_cnt++;
                end
                if (m_tick) m_ticks.push_back(n);
                if (s_tick) s_ticks.push_back(n);
                if (n == 290) m_at290 = am;
                if (n == 578) m_at578 = am;
            end
            d_hs_prev = d_hs;
        end
    end

    initial begin
        int unsigned bad;
        #2 resetn = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        run1 = 1'b1;
        resetn = 1'b1;
        repeat (6000) @(posedge clk);

        // Mid-line asynchronous reset: outputs must drop to reset values at once.
        #3;
        run1 = 1'b0;
        resetn = 1'b0;
        #1;
        chk("rst_dflt_disp", d_disp, 0);
        chk("rst_dflt_xy", d_x + d_y, 0);
        chk("rst_dflt_sync", {d_hs, d_vs, d_tick, d_blank, d_vclk}, 5'b11000);
        chk("rst_mid_all", {m_disp, m_hs, m_vs, m_tick, m_blank, m_vclk, m_x[7:0], m_y[7:0]},
            {6'b011000, 16'd0});
        chk("rst_small_all", {s_disp, s_hs, s_vs, s_tick, s_blank, s_x[7:0], s_y[7:0]},
            {5'b01100, 16'd0});
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #2;
        chk("restart_clk1_disp", d_disp, 0);
        @(posedge clk);
        #2;
        chk("restart_clk2_disp", d_disp, 1);
        chk("restart_clk2_x", d_x, 0);
        chk("restart_clk2_y", d_y, 0);
        repeat (2000) @(posedge clk);

        @(negedge clk);
        #1;
        chk("small_vclk_neg", s_vclk, 1);

        chk("dflt_hs_low_clocks", d_hs_low, 576);
        chk("dflt_disp_clocks", d_disp_cnt, 3840);
        chk("dflt_hs_falls", d_fall_n.size(), 3);
        if (d_fall_n.size() >= 2) begin
            chk("dflt_hs_fall_n", d_fall_n[0], 1314);
            chk("dflt_hs_fall_x", d_fall_x[0], 656);
            chk("dflt_line_period", d_fall_n[1] - d_fall_n[0], 1600);
        end
        chk("mid_vs_low_clocks", m_vs_low, 96);
        chk("mid_disp_pixels", m_disp_cnt / 2, 96);
        chk("mid_tick_count", m_ticks.size(), 10);
        if (m_ticks.size() > 0) chk("mid_tick_first", m_ticks[0], 290);
        bad = 0;
        for (int i = 1; i < m_ticks.size(); i++) if (m_ticks[i] - m_ticks[i-1] != 576) bad++;
        chk("mid_tick_period_errs", bad, 0);
        chk("mid_wrap_480", {m_at290.disp, m_at290.tick, m_at290.x[7:0], m_at290.y[7:0]},
            {2'b01, 8'd0, 8'd6});
        chk("mid_wrap_frame", {m_at578.disp, m_at578.tick, m_at578.x[7:0], m_at578.y[7:0]},
            {2'b10, 8'd0, 8'd0});
        chk("small_tick_count", s_ticks.size(), 71);
        if (s_ticks.size() > 0) chk("small_tick_first", s_ticks[0], 49);
        bad = 0;
        for (int i = 1; i < s_ticks.size(); i++) if (s_ticks[i] - s_ticks[i-1] != 84) bad++;
        chk("small_tick_period_errs", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
